// File: rtl/tucanos_process_scheduler.sv
// Round-robin scheduler for the three user-process slots.
// Tracks per-slot status from watchdog/IO/load events and hands the OS
// the next runnable process index plus its program base address.
module tucanos_process_scheduler #(
  parameter int unsigned           DATA_WIDTH        = 32,
  parameter int unsigned           ADDR_WIDTH        = 12,
  parameter logic [ADDR_WIDTH-1:0] PROCESS_BASE_ADDR = ADDR_WIDTH'(512),
  parameter logic [ADDR_WIDTH-1:0] PROCESS_SLOT_SIZE = ADDR_WIDTH'(1024)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  watchdog_request,
  input  logic [DATA_WIDTH-1:0] watchdog_code,
  input  logic                  io_complete,
  input  logic [1:0]            io_index,
  input  logic                  load_enable,
  input  logic [1:0]            load_index,
  output logic [1:0]            current_process,
  output logic                  schedule_valid,
  output logic [ADDR_WIDTH-1:0] process_base_address,
  output logic [5:0]            status_vector,
  output logic                  cpu_idle,
  output logic                  all_halted
);

  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_GRANT, S_RUN, S_DONE} state_t;
  typedef enum logic [1:0] {
    ST_EMPTY   = 2'b00,
    ST_READY   = 2'b01,
    ST_WAITING = 2'b10,
    ST_HALTED  = 2'b11
  } status_t;

  state_t     state;
  status_t    st      [3:1];
  status_t    st_next [3:1];

  logic       wd_valid, wd_wait, wd_halt;
  logic [3:1] is_cur, io_hit, ld_hit;
  logic       load_makes_ready;
  logic [3:0] ready_mask;
  logic       any_waiting;
  logic [1:0] s1, s2, s3, pick;
  logic       found;

  // Rotation successor; 0 (no process) maps to slot 1 so search starts at 1.
  function automatic logic [1:0] rr_succ(input logic [1:0] x);
    return (x == 2'd3) ? 2'd1 : x + 2'd1;
  endfunction

  // Program base of slot n, truncated to the address width.
  function automatic logic [ADDR_WIDTH-1:0] base_of(input logic [1:0] n);
    if (n == 2'd0) return '0;
    return PROCESS_BASE_ADDR + ADDR_WIDTH'(n - 2'd1) * PROCESS_SLOT_SIZE;
  endfunction

  // Classify a watchdog report; only codes 1..5 in RUN are acted upon.
  always_comb begin
    wd_valid = (state == S_RUN) && watchdog_request &&
               (watchdog_code >= DATA_WIDTH'(1)) && (watchdog_code <= DATA_WIDTH'(5));
    wd_wait  = wd_valid && (watchdog_code == DATA_WIDTH'(4));
    wd_halt  = wd_valid && (watchdog_code == DATA_WIDTH'(5));
  end

  // Next status per slot; IO completion and loads override a same-cycle wait/halt.
  always_comb begin
    is_cur = '0;
    io_hit = '0;
    ld_hit = '0;
    for (int i = 1; i <= 3; i++) begin
      st_next[i] = st[i];
      is_cur[i]  = (current_process == 2'(i));
      io_hit[i]  = io_complete && (io_index == 2'(i)) &&
                   ((st[i] == ST_WAITING) || (wd_wait && is_cur[i]));
      ld_hit[i]  = load_enable && (load_index == 2'(i)) &&
                   ((st[i] == ST_EMPTY) || (st[i] == ST_HALTED) || (wd_halt && is_cur[i]));
      if (io_hit[i] || ld_hit[i])   st_next[i] = ST_READY;
      else if (wd_wait && is_cur[i]) st_next[i] = ST_WAITING;
      else if (wd_halt && is_cur[i]) st_next[i] = ST_HALTED;
    end
    load_makes_ready = |ld_hit;
  end

  // Round-robin search over the registered table starting after the current slot.
  always_comb begin
    ready_mask  = '0;
    any_waiting = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      ready_mask[i] = (st[i] == ST_READY);
      if (st[i] == ST_WAITING) any_waiting = 1'b1;
    end
    s1    = rr_succ(current_process);
    s2    = rr_succ(s1);
    s3    = rr_succ(s2);
    found = 1'b1;
    pick  = s1;
    if (ready_mask[s1])      pick = s1;
    else if (ready_mask[s2]) pick = s2;
    else if (ready_mask[s3]) pick = s3;
    else begin
      found = 1'b0;
      pick  = 2'd0;
    end
  end

  // Scheduler FSM with registered outputs and status table.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state                <= S_IDLE;
      current_process      <= 2'd0;
      schedule_valid       <= 1'b0;
      process_base_address <= '0;
      cpu_idle             <= 1'b0;
      all_halted           <= 1'b0;
      for (int i = 1; i <= 3; i++) st[i] <= ST_EMPTY;
    end else begin
      for (int i = 1; i <= 3; i++) st[i] <= st_next[i];
      schedule_valid <= 1'b0;
      cpu_idle       <= 1'b0;
      case (state)
        S_IDLE: if (start) state <= S_SELECT;
        S_SELECT: begin
          if (found) begin
            state                <= S_GRANT;
            current_process      <= pick;
            process_base_address <= base_of(pick);
            schedule_valid       <= 1'b1;
          end else if (any_waiting) begin
            cpu_idle <= 1'b1;
          end else begin
            state                <= S_DONE;
            all_halted           <= 1'b1;
            current_process      <= 2'd0;
            process_base_address <= '0;
          end
        end
        S_GRANT: state <= S_RUN;
        S_RUN:   if (wd_valid) state <= S_SELECT;
        S_DONE: begin
          if (load_makes_ready || (|ready_mask)) begin
            state      <= S_SELECT;
            all_halted <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign status_vector = {st[3], st[2], st[1]};

endmodule
